// File: rtl/timer_pkg.sv
// Shared types and constants for the timer-board keypad scanner.
package timer_pkg;

  localparam int KEY_ROWS_DEF     = 4;
  localparam int KEY_COLS_DEF     = 4;
  localparam int KEY_SCAN_DIV_DEF = 1000;
  localparam int KEY_DEBOUNCE_DEF = 3;

  typedef enum logic {
    SCAN_RUN,
    SCAN_LAST
  } scan_st_t;

  function automatic int key_idx_w(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/key_prio_enc.sv
// Lowest-set-bit priority encoder: reports whether any request is set and
// the index of the lowest one.
module key_prio_enc #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  assign found = |req;

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/key_matrix_scanner.sv
// Matrix keypad scanner: column drive, row sync, full-frame debounce and
// one-cycle press events. Auto-repeat is built only with KEY_REPEAT_EN.
module key_matrix_scanner
  import timer_pkg::*;
#(
  parameter int ROWS         = KEY_ROWS_DEF,
  parameter int COLS         = KEY_COLS_DEF,
  parameter int SCAN_DIV     = KEY_SCAN_DIV_DEF,
  parameter int DEBOUNCE     = KEY_DEBOUNCE_DEF,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic                                mclk,
  input  logic                                mrst_n,
  input  logic [ROWS-1:0]                     ax_keyin,
  output logic [COLS-1:0]                     ax_keyout,
  output logic [ROWS*COLS-1:0]                key_map,
  output logic                                key_valid,
  output logic [key_idx_w(ROWS, COLS)-1:0]    key_code,
  output logic                                key_any
);

  localparam int N  = ROWS * COLS;
  localparam int KW = key_idx_w(ROWS, COLS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(COLS);

  if (SCAN_DIV < 4 || DEBOUNCE < 1 || DEBOUNCE > 15 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("key_matrix_scanner: parameter out of range");
  end

  logic [ROWS-1:0] rows_p0, rows_p1;
  scan_st_t        state, state_next;
  logic [DW-1:0]   dwell, dwell_next;
  logic [CW-1:0]   col;
  logic [N-1:0]    raw, frame_cur, prev, reported, pending;
  logic [3:0]      stable_cnt;
  logic            frame_end, eval;
  logic            found;
  logic [KW-1:0]   found_idx;
  logic            rep_fire;
  logic [KW-1:0]   rep_idx;

  // Stage p0/p1: two-flop synchroniser on the raw row lines
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      rows_p0 <= '0;
      rows_p1 <= '0;
    end else begin
      rows_p0 <= ax_keyin;
      rows_p1 <= rows_p0;
    end
  end

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      state <= SCAN_RUN;
      dwell <= '0;
    end else begin
      state <= state_next;
      dwell <= dwell_next;
    end
  end

  always_comb begin
    dwell_next = (state == SCAN_LAST) ? '0 : dwell + DW'(1);
    state_next = (dwell_next == DW'(SCAN_DIV - 1)) ? SCAN_LAST : SCAN_RUN;
  end

  // Raw frame including the column being latched this cycle, so the
  // debounce compare at frame_end sees the complete frame.
  always_comb begin
    frame_cur = raw;
    if (state == SCAN_LAST) frame_cur[int'(col)*ROWS +: ROWS] = rows_p1;
  end

  assign frame_end = (state == SCAN_LAST) && (col == CW'(COLS - 1));

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      col       <= '0;
      ax_keyout <= COLS'(1);
      raw       <= '0;
    end else if (state == SCAN_LAST) begin
      raw       <= frame_cur;
      col       <= (col == CW'(COLS - 1)) ? '0 : col + CW'(1);
      ax_keyout <= {ax_keyout[COLS-2:0], ax_keyout[COLS-1]};
    end
  end

  // Debounce stage: the map updates only on the increment reaching DEBOUNCE
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      prev       <= '0;
      stable_cnt <= '0;
      key_map    <= '0;
      eval       <= 1'b0;
    end else begin
      eval <= frame_end;
      if (frame_end) begin
        prev <= frame_cur;
        if (frame_cur == prev) begin
          if (stable_cnt < 4'(DEBOUNCE)) begin
            stable_cnt <= stable_cnt + 4'd1;
            if (stable_cnt + 4'd1 == 4'(DEBOUNCE)) key_map <= frame_cur;
          end
        end else begin
          stable_cnt <= '0;
        end
      end
    end
  end

  assign pending = key_map & ~reported;
  assign key_any = |key_map;

  key_prio_enc #(.N(N), .IDX_W(KW)) u_pend_enc (
    .req   (pending),
    .found (found),
    .idx   (found_idx)
  );

`ifdef KEY_REPEAT_EN
  logic [N-1:0] map_last;
  logic [7:0]   rep_cnt;
  logic         rep_armed, rep_found, single, rep_run;

  key_prio_enc #(.N(N), .IDX_W(KW)) u_rep_enc (
    .req   (key_map),
    .found (rep_found),
    .idx   (rep_idx)
  );

  assign single   = rep_found && ((key_map & (key_map - N'(1))) == '0);
  assign rep_run  = single && (key_map == map_last) && (pending == '0);
  assign rep_fire = rep_run &&
                    (rep_cnt + 8'd1 == (rep_armed ? 8'(REPEAT_RATE) : 8'(REPEAT_DELAY)));

  // Frame counter toward the first repeat, then between repeats
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      map_last  <= '0;
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (eval) begin
      map_last <= key_map;
      if (!rep_run) begin
        rep_cnt   <= '0;
        rep_armed <= 1'b0;
      end else if (rep_fire) begin
        rep_cnt   <= '0;
        rep_armed <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + 8'd1;
      end
    end
  end
`else
  assign rep_fire = 1'b0;
  assign rep_idx  = '0;
`endif

  // Event stage: one report slot per frame, new presses before repeats
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      reported  <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      key_valid <= 1'b0;
      if (eval && found) begin
        key_valid <= 1'b1;
        key_code  <= found_idx;
        reported  <= (reported & key_map) | (N'(1) << found_idx);
      end else begin
        reported <= reported & key_map;
        if (eval && rep_fire) begin
          key_valid <= 1'b1;
          key_code  <= rep_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner with a 4x4 press-table matrix model.
module tb_key_matrix_scanner;

  logic        mclk = 1'b0;
  logic        mrst_n;
  logic [3:0]  ax_keyin;
  logic [3:0]  ax_keyout;
  logic [15:0] key_map;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_any;

  logic [15:0] pressed = '0;
  int          checks  = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          ev_code[$];
  int          ev_cyc[$];
  int          press_cyc;

  key_matrix_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3),
    .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .mclk      (mclk),
    .mrst_n    (mrst_n),
    .ax_keyin  (ax_keyin),
    .ax_keyout (ax_keyout),
    .key_map   (key_map),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_any   (key_any)
  );

  always #5 mclk = ~mclk;

  // Matrix: a closed key connects its column drive to its row line
  always_comb begin
    ax_keyin = '0;
    for (int c = 0; c < 4; c++)
      if (ax_keyout[c]) ax_keyin = ax_keyin | pressed[c*4 +: 4];
  end

  initial begin
    forever begin
      @(negedge mclk);
      cyc = cyc + 1;
      if (mrst_n === 1'b1 && key_valid === 1'b1) begin
        ev_code.push_back(int'(key_code));
        ev_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge mclk);
    #1;
  endtask

  task automatic clear_events();
    ev_code.delete();
    ev_cyc.delete();
  endtask

  function automatic int code_at(input int i);
    return (i < ev_code.size()) ? ev_code[i] : -1;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < ev_cyc.size()) ? ev_cyc[i] : -1000;
  endfunction

  initial begin
    mrst_n = 1'b0;
    step(3);
    check("rst_keyout", 32'(ax_keyout), 32'h1);
    check("rst_map",    32'(key_map),   32'h0);
    check("rst_valid",  32'(key_valid), 32'h0);
    check("rst_code",   32'(key_code),  32'h0);
    check("rst_any",    32'(key_any),   32'h0);

    // Column rotation: 4 cycles per column from reset release
    @(negedge mclk);
    mrst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge mclk);
      #1;
      check($sformatf("scan_col_k%0d", k), 32'(ax_keyout), 32'(1 << ((k / 4) % 4)));
    end
    step(64);
    check("idle_events", ev_code.size(), 0);
    check("idle_map", 32'(key_map), 32'h0);

    // Single key col 2 / row 1 -> code 9
    clear_events();
    pressed[9] = 1'b1;
    press_cyc  = cyc;
    step(96);
    check("k9_count", ev_code.size(), 1);
    check("k9_code", code_at(0), 9);
    check("k9_latency_le_80", 32'(cyc_at(0) - press_cyc <= 80), 1);
    check("k9_map", 32'(key_map), 32'h0200);
    check("k9_any", 32'(key_any), 1);
    step(64);
    check("k9_held_no_repeat", ev_code.size(), 1);
    pressed[9] = 1'b0;
    step(96);
    check("k9_release_map", 32'(key_map), 32'h0);
    check("k9_release_no_event", ev_code.size(), 1);

    // Bounce key 0 every 10 cycles for 6 frames, then hold
    clear_events();
    for (int i = 0; i < 96; i++) begin
      if (i % 10 == 0) pressed[0] = ~pressed[0];
      step(1);
    end
    pressed[0] = 1'b1;
    check("bounce_no_event", ev_code.size(), 0);
    check("bounce_map_held", 32'(key_map), 32'h0);
    step(80);
    check("bounce_hold_count", ev_code.size(), 1);
    check("bounce_hold_code", code_at(0), 0);
    pressed[0] = 1'b0;
    step(96);

    // Simultaneous codes 3 and 14
    clear_events();
    pressed[3]  = 1'b1;
    pressed[14] = 1'b1;
    step(112);
    check("multi_count", ev_code.size(), 2);
    check("multi_first", code_at(0), 3);
    check("multi_second", code_at(1), 14);
    check("multi_gap_frame", cyc_at(1) - cyc_at(0), 16);
    pressed[3]  = 1'b0;
    pressed[14] = 1'b0;
    step(96);
    check("multi_release_map", 32'(key_map), 32'h0);
    check("multi_release_count", ev_code.size(), 2);
    pressed[3] = 1'b1;
    step(96);
    check("repress_count", ev_code.size(), 3);
    check("repress_code", code_at(2), 3);

    // Asynchronous reset mid-frame with key 3 held
    step(7);
    mrst_n = 1'b0;
    #1;
    check("midrst_keyout", 32'(ax_keyout), 32'h1);
    check("midrst_map",    32'(key_map),   32'h0);
    check("midrst_valid",  32'(key_valid), 32'h0);
    check("midrst_code",   32'(key_code),  32'h0);
    check("midrst_any",    32'(key_any),   32'h0);
    step(3);
    clear_events();
    mrst_n = 1'b1;
    step(96);
    check("postrst_count", ev_code.size(), 1);
    check("postrst_code", code_at(0), 3);
    check("postrst_map", 32'(key_map), 32'h0008);

`ifdef KEY_REPEAT_EN
    pressed[3] = 1'b0;
    step(96);
    clear_events();
    pressed[5] = 1'b1;
    step(256);
    check("rep_first_code", code_at(0), 5);
    check("rep_gap_delay", cyc_at(1) - cyc_at(0), 64);
    check("rep_gap_rate1", cyc_at(2) - cyc_at(1), 32);
    check("rep_gap_rate2", cyc_at(3) - cyc_at(2), 32);
    check("rep_code", code_at(3), 5);
    pressed[10] = 1'b1;
    step(96);
    clear_events();
    step(160);
    check("rep_stopped", ev_code.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
